// File: rtl/sdm_dac.sv
// -----------------------------------------------------------------------------
// sdm_dac -- first-order sigma-delta DAC front end
//
// Takes N-bit unsigned samples over a valid/ready handshake. Each sample is
// played for OSR clock cycles as a 1-bit pulse-density stream whose
// ones-density is sample/2^N; an external RC filter recovers the analog level.
// A one-entry holding register lets upstream deliver the next sample while the
// current one is still playing.
//
// Parameters:
//   N    sample resolution in bits (2..16)
//   OSR  clock cycles per sample (>= 2)
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst           asynchronous active-high reset
//   en            modulator enable; low forces IDLE (hold buffer kept)
//   sample_in     unsigned sample, 0 = zero scale
//   sample_valid  sample_in valid
//   sample_ready  holding register can accept a sample this cycle
//   dac_out       registered pulse-density bit
//   busy          high while modulating (RUN)
//   underrun      one-cycle pulse: sample period ended with empty hold register
//
// Optional build macro:
//   SDM_DITHER_EN  adds a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed
//                  16'hACE1) whose bit 0 is used as carry-in to the
//                  accumulator sum, breaking up idle tones.
// -----------------------------------------------------------------------------
module sdm_dac #(
    parameter int N   = 8,
    parameter int OSR = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] sample_in,
    input  logic         sample_valid,
    output logic         sample_ready,
    output logic         dac_out,
    output logic         busy,
    output logic         underrun
);

    localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_reg;
    logic [N-1:0]   acc_reg;
    logic [N-1:0]   active_reg;
    logic [N-1:0]   hold_reg;
    logic           hold_full_reg;
    logic [CW-1:0]  osr_cnt_reg;
    logic           dac_out_reg;
    logic           busy_reg;
    logic           underrun_reg;

    logic           boundary;
    logic           load_now;
    logic           transfer;
    logic           cin;
    logic [N:0]     sum;

    // Last cycle of a sample period.
    assign boundary = (state_reg == RUN) && (osr_cnt_reg == CW'(OSR - 1));

    // Hold moves into active either on start-up from IDLE or at a period end.
    assign load_now = en && hold_full_reg && ((state_reg == IDLE) || boundary);

    // A drain and a fill may happen on the same cycle.
    assign sample_ready = en && (!hold_full_reg || load_now);
    assign transfer     = sample_valid && sample_ready;

    // Top bit of the (N+1)-bit sum is the modulator output; the low N bits
    // are the residue carried into the next cycle.
    assign sum = {1'b0, acc_reg} + {1'b0, active_reg} + {{N{1'b0}}, cin};

`ifdef SDM_DITHER_EN
    logic [15:0] lfsr_reg;

    // Free-running while modulating; deliberately untouched by en so the
    // sequence does not restart identically after every enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= 16'hACE1;
        end else if (state_reg == RUN) begin
            lfsr_reg <= {lfsr_reg[14:0],
                         lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign cin = lfsr_reg[0];
`else
    assign cin = 1'b0;
`endif

    // Holding register: a transfer always wins over a drain, which is what
    // makes the same-cycle drain-and-fill case keep hold_full set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else if (transfer) begin
            hold_reg      <= sample_in;
            hold_full_reg <= 1'b1;
        end else if (load_now) begin
            hold_full_reg <= 1'b0;
        end
    end

    // Modulator FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            active_reg   <= '0;
            osr_cnt_reg  <= '0;
            dac_out_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            underrun_reg <= 1'b0;
            if (!en) begin
                state_reg   <= IDLE;
                acc_reg     <= '0;
                active_reg  <= '0;
                osr_cnt_reg <= '0;
                dac_out_reg <= 1'b0;
                busy_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        acc_reg     <= '0;
                        osr_cnt_reg <= '0;
                        dac_out_reg <= 1'b0;
                        if (hold_full_reg) begin
                            active_reg <= hold_reg;
                            state_reg  <= RUN;
                            busy_reg   <= 1'b1;
                        end else begin
                            busy_reg   <= 1'b0;
                        end
                    end
                    RUN: begin
                        busy_reg    <= 1'b1;
                        acc_reg     <= sum[N-1:0];
                        dac_out_reg <= sum[N];
                        if (boundary) begin
                            osr_cnt_reg <= '0;
                            // acc is not cleared here: the quantisation
                            // error carries over into the next sample.
                            if (hold_full_reg) begin
                                active_reg <= hold_reg;
                            end else begin
                                underrun_reg <= 1'b1;
                            end
                        end else begin
                            osr_cnt_reg <= osr_cnt_reg + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign dac_out  = dac_out_reg;
    assign busy     = busy_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_sdm_dac.sv
// -----------------------------------------------------------------------------
// tb_sdm_dac -- self-checking bench for sdm_dac (N=8, OSR=16, no dither)
//
// The reference model keeps a queue for the holding buffer and a running
// total of the played sample values; the expected output bit in each
// modulating cycle is the change in floor(total / 2^N).
// -----------------------------------------------------------------------------
module tb_sdm_dac;

    localparam int N   = 8;
    localparam int OSR = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [N-1:0] sample_in = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         dac_out;
    logic         busy;
    logic         underrun;

    sdm_dac #(.N(N), .OSR(OSR)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dac_out      (dac_out),
        .busy         (busy),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int    m_pend[$];     // holding buffer (0 or 1 entries)
    bit    m_run;
    int    m_cur;         // sample being played
    int    m_phase;       // cycle index within the sample period
    longint m_total;      // sum of played sample values since start of run
    bit    m_dac, m_under;
    bit    last_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_run   = 0;
        m_cur   = 0;
        m_phase = 0;
        m_total = 0;
        m_dac   = 0;
        m_under = 0;
    endtask

    // Async reset: outputs must clear without any clock edge.
    task automatic do_reset();
        @(negedge clk);
        en = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        rst = 1'b1;
        #1;
        check("rst_dac", dac_out, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check ready, clock, check outputs.
    task automatic step(input logic en_i, input logic v_i, input logic [N-1:0] d_i);
        bit ld, exp_rdy, xfer;
        @(negedge clk);
        en = en_i;
        sample_valid = v_i;
        sample_in = d_i;
        ld = en_i && (m_pend.size() != 0) && (!m_run || m_phase == OSR - 1);
        exp_rdy = en_i && ((m_pend.size() == 0) || ld);
        xfer = v_i && exp_rdy;
        #1;
        check("ready", sample_ready, exp_rdy);
        last_rdy = sample_ready;
        @(posedge clk);
        m_under = 0;
        if (!en_i) begin
            m_run = 0; m_cur = 0; m_phase = 0; m_total = 0; m_dac = 0;
        end else if (!m_run) begin
            m_dac = 0;
            if (ld) begin
                m_cur = m_pend[0];
                m_run = 1; m_phase = 0; m_total = 0;
            end
        end else begin
            m_dac = ((m_total + m_cur) / (1 << N)) != (m_total / (1 << N));
            m_total += m_cur;
            if (m_phase == OSR - 1) begin
                m_phase = 0;
                if (ld) m_cur = m_pend[0];
                else    m_under = 1;
            end else begin
                m_phase++;
            end
        end
        if (ld) void'(m_pend.pop_front());
        if (xfer) m_pend.push_back(int'(d_i));
        #1;
        check("dac_out", dac_out, m_dac);
        check("busy", busy, m_run);
        check("underrun", underrun, m_under);
    endtask

    typedef struct {
        logic [7:0] s;
        int ones16;
        int ones256;
        int unders;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int ones_a, ones_b, unders, rdy_cnt;

        vecs[0] = '{8'h00,  0,   0, 16};
        vecs[1] = '{8'h80,  8, 128, 16};
        vecs[2] = '{8'hFF, 15, 255, 16};
        vecs[3] = '{8'h40,  4,  64, 16};
        vecs[4] = '{8'h01,  0,   1, 16};
        vecs[5] = '{8'h11,  1,  17, 16};
        vecs[6] = '{8'hC0, 12, 192, 16};
        vecs[7] = '{8'h7F,  7, 127, 16};

        // Reset / idle: enabled with no samples, nothing moves.
        do_reset();
        for (int i = 0; i < 50; i++) step(1, 0, 0);

        // Constant-sample table: single sample, repeats via underrun.
        foreach (vecs[k]) begin
            do_reset();
            step(1, 1, vecs[k].s);   // transfer
            step(1, 0, 0);           // load into active
            check("load_busy", busy, 1);
            ones_a = 0; ones_b = 0; unders = 0;
            for (int c = 0; c < 256; c++) begin
                step(1, 0, 0);
                if (c < 16) ones_a += int'(dac_out);
                ones_b += int'(dac_out);
                unders += int'(underrun);
            end
            check($sformatf("ones16_%02h", vecs[k].s), ones_a, vecs[k].ones16);
            check($sformatf("ones256_%02h", vecs[k].s), ones_b, vecs[k].ones256);
            check($sformatf("underruns_%02h", vecs[k].s), unders, vecs[k].unders);
        end

        // Extremes back-to-back: 0x00 then 0xFF.
        do_reset();
        step(1, 1, 8'h00);
        step(1, 1, 8'hFF);           // load of 0x00 and refill in one cycle
        ones_a = 0; ones_b = 0; unders = 0;
        for (int c = 0; c < 32; c++) begin
            step(1, 0, 0);
            if (c < 16) ones_a += int'(dac_out);
            else        ones_b += int'(dac_out);
            if (c < 31) unders += int'(underrun);
        end
        check("extreme_zero_ones", ones_a, 0);
        check("extreme_full_ones", ones_b, 15);
        check("extreme_underruns", unders, 0);

        // Backpressure: valid held high, one transfer per period.
        do_reset();
        rdy_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            step(1, 1, N'($urandom));
            if (c >= 20 && c < 276) rdy_cnt += int'(last_rdy);
        end
        check("bp_transfers_256", rdy_cnt, 16);

        // en drop at osr_cnt=7 with a sample waiting in hold.
        do_reset();
        step(1, 1, 8'h80);
        step(1, 0, 0);               // load, osr_cnt=0
        step(1, 1, 8'h30);           // fills hold while playing
        for (int c = 0; c < 6; c++) step(1, 0, 0);  // now osr_cnt=7
        step(0, 0, 0);
        check("endrop_dac", dac_out, 0);
        check("endrop_busy", busy, 0);
        for (int c = 0; c < 3; c++) step(0, 1, 8'h55);  // ignored, ready=0
        step(1, 0, 0);               // restart from hold with acc=0
        check("restart_busy", busy, 1);
        for (int c = 0; c < 40; c++) step(1, 0, 0);

        // Reset mid-sample drops the buffered sample too.
        step(1, 1, 8'h99);
        step(1, 0, 0);
        do_reset();
        for (int c = 0; c < 4; c++) step(1, 0, 0);

        // Randomised traffic with occasional en drops.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0), N'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
